// File: rtl/main_buf_pkg.sv
// rtl/main_buf_pkg.sv - shared types and helpers for the main-buffer loader
package main_buf_pkg;

   typedef enum logic [1:0] {
      DEST_IFM  = 2'd0,
      DEST_WGT  = 2'd1,
      DEST_BIAS = 2'd2,
      DEST_NONE = 2'd3
   } dest_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IFM,
      ST_WGT,
      ST_BIAS,
      ST_DRAIN
   } ld_state_e;

   function automatic int vec_words(input int elems, input int lanes);
      return (elems + lanes - 1) / lanes;
   endfunction

   // A lane survives masking when its index is below the count of real elements in the word.
   function automatic logic lane_kept(input int lane, input int keep);
      return lane < keep;
   endfunction

endpackage

// File: rtl/main_buf_tx_slice.sv
// rtl/main_buf_tx_slice.sv - single-entry valid/ready output register toward the main buffer
module main_buf_tx_slice
   import main_buf_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  dest_e            dest_i,
   input  logic             respond_i,
   output logic [WIDTH-1:0] data_o,
   output dest_e            dest_o,
   output logic             send_o
);

   logic [WIDTH-1:0] data_q, data_d;
   dest_e            dest_q, dest_d;
   logic             send_q, send_d;

   // The parent only loads when the slot is empty or draining this cycle.
   always_comb begin
      data_d = data_q;
      dest_d = dest_q;
      send_d = send_q;
      if (load_i) begin
         data_d = data_i;
         dest_d = dest_i;
         send_d = 1'b1;
      end else if (send_q && respond_i) begin
         dest_d = DEST_NONE;
         send_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         dest_q <= DEST_NONE;
         send_q <= 1'b0;
      end else begin
         data_q <= data_d;
         dest_q <= dest_d;
         send_q <= send_d;
      end
   end

   assign data_o = data_q;
   assign dest_o = dest_q;
   assign send_o = send_q;

endmodule

// File: rtl/main_buf_loader.sv
// rtl/main_buf_loader.sv - streams one IFM/WGT/BIAS tile frame into the main buffer
module main_buf_loader
   import main_buf_pkg::*;
#(
   parameter int INPUT_WIDTH    = 32,
   parameter int OUTPUT_WIDTH   = 8,
   parameter int NUM_OF_OUTPUTS = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   reuse_wgt,
   input  logic                   src_valid,
   input  logic [INPUT_WIDTH-1:0] src_data,
   output logic                   src_ready,
   output logic [INPUT_WIDTH-1:0] main_input,
   output logic [1:0]             signal,
   output logic                   send,
   input  logic                   respond,
   output logic                   busy,
   output logic                   done
);

   localparam int LANES     = INPUT_WIDTH / OUTPUT_WIDTH;
   localparam int VEC_WORDS = vec_words(NUM_OF_OUTPUTS, LANES);
   localparam int LAST_KEEP = NUM_OF_OUTPUTS - (VEC_WORDS - 1) * LANES;
   localparam int WCNT_W    = (VEC_WORDS > 1) ? $clog2(VEC_WORDS) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(VEC_WORDS - 1);

   ld_state_e              state_q;
   logic [WCNT_W-1:0]      wcnt_q;
   logic                   reuse_q;

   logic                   phase_active;
   logic                   accept;
   logic                   xfer;
   logic                   last_word;
   dest_e                  phase_dest;
   dest_e                  out_dest;
   int                     keep_n;
   logic [INPUT_WIDTH-1:0] masked;

   assign phase_active = (state_q == ST_IFM) || (state_q == ST_WGT) || (state_q == ST_BIAS);
   assign src_ready    = phase_active && (!send || respond);
   assign accept       = src_valid && src_ready;
   assign xfer         = send && respond;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DRAIN) && xfer;

   always_comb begin
      phase_dest = DEST_NONE;
      last_word  = 1'b0;
      keep_n     = LANES;
      case (state_q)
         ST_IFM: begin
            phase_dest = DEST_IFM;
            last_word  = (wcnt_q == WCNT_LAST);
            if (last_word) keep_n = LAST_KEEP;
         end
         ST_WGT: begin
            phase_dest = DEST_WGT;
            last_word  = (wcnt_q == WCNT_LAST);
            if (last_word) keep_n = LAST_KEEP;
         end
         ST_BIAS: begin
            phase_dest = DEST_BIAS;
            last_word  = 1'b1;
            keep_n     = 1;
         end
         default: ;
      endcase
   end

   // Padding lanes beyond the vector length are zeroed so the buffer never sees stale bytes.
   always_comb begin
      masked = src_data;
      for (int k = 0; k < LANES; k++) begin
         if (!lane_kept(k, keep_n)) masked[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         reuse_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_IFM;
                  reuse_q <= reuse_wgt;
                  wcnt_q  <= '0;
               end
            end
            ST_IFM, ST_WGT: begin
               if (accept) begin
                  if (last_word) begin
                     wcnt_q <= '0;
                     if (state_q == ST_WGT) state_q <= ST_BIAS;
                     else                   state_q <= reuse_q ? ST_DRAIN : ST_WGT;
                  end else begin
                     wcnt_q <= wcnt_q + 1'b1;
                  end
               end
            end
            ST_BIAS: begin
               if (accept) begin
                  wcnt_q  <= '0;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (xfer) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   main_buf_tx_slice #(
      .WIDTH (INPUT_WIDTH)
   ) u_tx_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .data_i    (masked),
      .dest_i    (phase_dest),
      .respond_i (respond),
      .data_o    (main_input),
      .dest_o    (out_dest),
      .send_o    (send)
   );

   assign signal = out_dest;

endmodule

// File: tb/tb_main_buf_loader.sv
// tb/tb_main_buf_loader.sv - self-checking bench for main_buf_loader
module tb_main_buf_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        reuse_wgt;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic [31:0] main_input;
   logic [1:0]  signal;
   logic        send;
   logic        respond;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   main_buf_loader #(
      .INPUT_WIDTH    (32),
      .OUTPUT_WIDTH   (8),
      .NUM_OF_OUTPUTS (9)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .reuse_wgt  (reuse_wgt),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .main_input (main_input),
      .signal     (signal),
      .send       (send),
      .respond    (respond),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [31:0] src;
      logic [31:0] exp_data;
      logic [1:0]  exp_sig;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  s;
   } exp_t;

   vec_t tbl[7];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic run_frame(input bit reuse, input int gap, input int stall_idx, input int stall_len,
                            input int abort_after, input int sa1, input int sa2,
                            output int n_done, output int done_cyc, output int n_xfer, output int n_gap_low);
      int          n;
      int          si;
      int          oi;
      int          gapc;
      int          stallc;
      int          cyc;
      bit          fin;
      logic [31:0] hold;
      exp_t        e;
      n = reuse ? 3 : 7;
      si = 0; oi = 0; gapc = 0; stallc = 0; cyc = 0; fin = 1'b0; hold = '0;
      n_done = 0; done_cyc = -1; n_gap_low = 0;
      while (!fin && cyc < 200) begin
         start     = (cyc == 0) || (cyc == sa1) || (cyc == sa2);
         reuse_wgt = reuse;
         src_valid = (cyc > 0) && (si < 7) && (gapc == 0);
         src_data  = (si < 7) ? tbl[si].src : 32'h0;
         respond   = !((oi == stall_idx) && (stallc < stall_len));
         @(negedge clk);
         if (send && !respond) begin
            if (stallc == 0) begin
               hold = main_input;
               check("stall_word", main_input, tbl[stall_idx].exp_data);
            end else begin
               check("stall_data_stable", main_input, hold);
            end
            check("stall_src_ready", src_ready, 1'b0);
            stallc++;
         end
         if (!send) begin
            check("idle_signal", signal, 2'd3);
            if (oi > 0 && oi < n) n_gap_low++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (send && respond) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 0, 1);
            end else begin
               e = sb.pop_front();
               check("out_data", main_input, e.d);
               check("out_signal", signal, e.s);
            end
            check("done_on_last", done, (oi == n - 1));
            oi++;
            if (oi == n || oi == abort_after) fin = 1'b1;
         end
         if (src_valid && src_ready) begin
            check("accept_in_frame", (si < n), 1'b1);
            sb.push_back('{d: tbl[si].exp_data, s: tbl[si].exp_sig});
            si++;
            gapc = gap;
         end else if (gapc > 0) begin
            gapc--;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("frame_finished", fin, 1'b1);
      n_xfer    = oi;
      start     = 1'b0;
      src_valid = 1'b0;
      respond   = 1'b1;
   endtask

   task automatic idle_check(input int cycles);
      int n_act;
      n_act = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (done || send || busy || src_ready) n_act++;
      end
      check("idle_quiet", n_act, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nd, dc, nx, ng;
      tbl[0] = '{src: 32'h04030201, exp_data: 32'h04030201, exp_sig: 2'd0};
      tbl[1] = '{src: 32'h08070605, exp_data: 32'h08070605, exp_sig: 2'd0};
      tbl[2] = '{src: 32'hAABBCC09, exp_data: 32'h00000009, exp_sig: 2'd0};
      tbl[3] = '{src: 32'h11111111, exp_data: 32'h11111111, exp_sig: 2'd1};
      tbl[4] = '{src: 32'h22222222, exp_data: 32'h22222222, exp_sig: 2'd1};
      tbl[5] = '{src: 32'h333333FF, exp_data: 32'h000000FF, exp_sig: 2'd1};
      tbl[6] = '{src: 32'h777777B5, exp_data: 32'h000000B5, exp_sig: 2'd2};

      rst_n = 1'b0; start = 1'b0; reuse_wgt = 1'b0;
      src_valid = 1'b0; src_data = '0; respond = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_main_input", main_input, 32'h0);
      check("rst_signal", signal, 2'd3);
      check("rst_send", send, 1'b0);
      check("rst_src_ready", src_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame(1'b0, 0, -1, 0, 0, -1, -1, nd, dc, nx, ng);
      check("full_done_count", nd, 1);
      check("full_done_cycle", dc, 8);
      check("full_xfers", nx, 7);
      check("full_no_gaps", ng, 0);
      idle_check(3);

      run_frame(1'b1, 0, -1, 0, 0, -1, -1, nd, dc, nx, ng);
      check("reuse_done_count", nd, 1);
      check("reuse_done_cycle", dc, 4);
      check("reuse_xfers", nx, 3);
      check("reuse_sb_empty", sb.size(), 0);
      idle_check(3);

      run_frame(1'b0, 0, 1, 5, 0, -1, -1, nd, dc, nx, ng);
      check("stall_done_count", nd, 1);
      check("stall_done_cycle", dc, 13);
      check("stall_xfers", nx, 7);
      check("stall_sb_empty", sb.size(), 0);
      idle_check(3);

      run_frame(1'b0, 2, -1, 0, 0, -1, -1, nd, dc, nx, ng);
      check("gap_done_count", nd, 1);
      check("gap_xfers", nx, 7);
      check("gap_send_low_cycles", ng, 12);
      idle_check(3);

      run_frame(1'b0, 0, -1, 0, 5, -1, -1, nd, dc, nx, ng);
      check("abort_xfers", nx, 5);
      check("abort_no_done", nd, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_main_input", main_input, 32'h0);
      check("arst_signal", signal, 2'd3);
      check("arst_send", send, 1'b0);
      check("arst_src_ready", src_ready, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(1'b0, 0, -1, 0, 0, -1, -1, nd, dc, nx, ng);
      check("rerun_done_count", nd, 1);
      check("rerun_done_cycle", dc, 8);
      check("rerun_xfers", nx, 7);
      idle_check(3);

      run_frame(1'b0, 0, -1, 0, 0, 5, 8, nd, dc, nx, ng);
      check("ignore_start_done_count", nd, 1);
      check("ignore_start_done_cycle", dc, 8);
      idle_check(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/main_buf_loader.md
# main_buf_loader

Transmit side of the main-buffer load interface. Pulls packed 32-bit words from an upstream stream source (DMA/FIFO) and sends one tile frame to the main buffer: IFM vector words, then weight vector words, then the bias word. Each word is tagged with its destination select and held until the buffer acknowledges it. Sits between the memory front-end and the main buffer's 1-to-3 demux.

## Interface
- `INPUT_WIDTH`, default 32: stream and buffer word width.
- `OUTPUT_WIDTH`, default 8: element width; lane k of a word is bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- `NUM_OF_OUTPUTS`, default 9: elements per IFM vector and per weight vector.
- Derived (localparam): `LANES` = INPUT_WIDTH/OUTPUT_WIDTH = 4; `VEC_WORDS` = ceil(NUM_OF_OUTPUTS/LANES) = 3.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `start`, in, 1: request one frame; sampled only in IDLE.
- `reuse_wgt`, in, 1: sampled with `start`; 1 means send the IFM phase only.
- `src_valid`, in, 1: upstream word valid.
- `src_data`, in, INPUT_WIDTH: upstream word.
- `src_ready`, out, 1: loader accepts `src_data`.
- `main_input`, out, INPUT_WIDTH: word to main buffer.
- `signal`, out, 2: destination; 0 = IFM, 1 = WGT, 2 = BIAS, 3 = none.
- `send`, out, 1: `main_input`/`signal` valid.
- `respond`, in, 1: main buffer accepts the current word.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse when the frame's last word transfers.

## Operation
- FSM states: IDLE, IFM, WGT, BIAS, DRAIN.
- IDLE → IFM on `start`. `reuse_wgt` is latched into `reuse_q` on the same edge.
- Word counter `wcnt` counts from 0 to VEC_WORDS-1 in IFM and WGT, and is cleared on every phase change. BIAS lasts exactly 1 word.
- Phase advances when the phase's last word is accepted upstream (`src_valid && src_ready`):
  - IFM → WGT, or IFM → DRAIN if `reuse_q`.
  - WGT → BIAS.
  - BIAS → DRAIN.
- DRAIN → IDLE on the downstream transfer (`send && respond`). `done` pulses in that cycle.
- A source accept loads a single-entry output register with the data, masked as below, and the phase's `signal` code.
- Masking: in the last word of a vector, lanes with index ≥ NUM_OF_OUTPUTS - (VEC_WORDS-1)*LANES are forced to 0, so lanes 1..3 of word 2 are cleared. The bias word keeps lane 0 only.
- `src_ready` = (state ∈ {IFM, WGT, BIAS}) && (!send || respond). Back-to-back transfers run at 1 word/cycle.
- `busy` = state ≠ IDLE.
- `start` while busy is ignored. `start` in the same cycle as the DRAIN exit is also ignored.
- No data reordering and no sign handling: bytes pass through unchanged except for the lane masking.

## Timing
- Reset values: `main_input` = 0, `signal` = 3, `send` = 0, `src_ready` = 0, `busy` = 0, `done` = 0, state = IDLE, `wcnt` = 0, `reuse_q` = 0.
- Latency: a source accept at edge N gives `send` high after edge N, valid in cycle N+1.
- Handshake: while `send && !respond`, `main_input` and `signal` are stable and `src_ready` = 0. Upstream stalls never drop `send` once it is asserted.
- On `send && respond` with no new accept, `send` falls and `signal` returns to 3 on the next edge.
- Minimum frame is 7 downstream transfers (3 with `reuse_wgt`). At full throughput, `done` comes 8 cycles after `start` (4 with `reuse_wgt`).
- `rst_n` low mid-frame: all state clears immediately. The partial frame is discarded and no `done` is issued.

## Structure
- Package `main_buf_pkg`:
  - `dest_e` enum (IFM = 0, WGT = 1, BIAS = 2, NONE = 3).
  - `ld_state_e` enum.
  - `VEC_WORDS` function.
  - Lane-mask function.
- Sub-module `main_buf_tx_slice`: the single-entry valid/ready output register (data, dest, `send`/`respond`).
- The top level holds the FSM, `wcnt`, and the masking logic.

## Test plan
- `start`, `reuse_wgt` = 0, source words 0x04030201, 0x08070605, 0xAABBCC09, 0x11…, 0x22…, 0x333333FF, 0x777777B5, `respond` = 1:
  - `signal` sequence 0,0,0,1,1,1,2.
  - Word 2 goes out as 0x00000009, word 5 as 0x000000FF, the bias word as 0x000000B5.
  - `done` pulses in cycle 8.
- Same frame with `reuse_wgt` = 1: exactly 3 transfers, all `signal` = 0. `done` follows the third; no WGT/BIAS words are accepted.
- `respond` held low for 5 cycles on word 1:
  - `main_input` stays 0x08070605 and `src_ready` stays 0 throughout.
  - The frame completes with no loss or duplication.
- `src_valid` gaps of 2 cycles between words: `send` deasserts between words with `signal` = 3, and the ordering is preserved.
- `rst_n` pulsed low after word 4:
  - All outputs return to reset values asynchronously.
  - A following `start` resends from IFM word 0.
- `start` asserted during WGT and during the DRAIN exit cycle: both ignored, so only one `done` is seen.
